// File: rtl/cpu_record_extractor_pkg.sv
// Shared definitions for the cpu trace checker/extractor pair:
// ASCII codes, parser phases, record format codes and char classifiers.
package cpu_record_extractor_pkg;

  localparam logic [6:0] ASC_CARET  = 7'h5e;
  localparam logic [6:0] ASC_AT     = 7'h40;
  localparam logic [6:0] ASC_COLON  = 7'h3a;
  localparam logic [6:0] ASC_SPACE  = 7'h20;
  localparam logic [6:0] ASC_DOLLAR = 7'h24;
  localparam logic [6:0] ASC_STAR   = 7'h2a;
  localparam logic [6:0] ASC_LT     = 7'h3c;
  localparam logic [6:0] ASC_EQ     = 7'h3d;
  localparam logic [6:0] ASC_HASH   = 7'h23;
  localparam logic [6:0] ASC_0      = 7'h30;
  localparam logic [6:0] ASC_9      = 7'h39;
  localparam logic [6:0] ASC_LA     = 7'h61;
  localparam logic [6:0] ASC_LF     = 7'h66;

  localparam logic [1:0] FMT_NONE = 2'b00;
  localparam logic [1:0] FMT_REG  = 2'b01;
  localparam logic [1:0] FMT_MEM  = 2'b10;

  typedef enum logic [2:0] {
    PhIdle, PhTime, PhPc, PhSep, PhReg, PhAddr, PhArrow, PhData
  } phase_e;

  function automatic logic is_digit(input logic [6:0] c);
    return (c >= ASC_0) && (c <= ASC_9);
  endfunction

  // Lower-case hex only; upper-case letters are not part of the trace format.
  function automatic logic is_hex(input logic [6:0] c);
    return is_digit(c) || ((c >= ASC_LA) && (c <= ASC_LF));
  endfunction

  function automatic logic [3:0] hex2nib(input logic [6:0] c);
    return is_digit(c) ? c[3:0] : c[3:0] + 4'd9;
  endfunction

endpackage

// File: rtl/cpu_record_extractor_record_out_reg.sv
// Output holding register for extracted records: valid/ready handshake
// plus a saturating count of records lost to back-pressure.
module record_out_reg #(
  parameter int unsigned TIME_W = 14,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [1:0]        ld_type,
  input  logic [TIME_W-1:0] ld_time,
  input  logic [31:0]       ld_pc,
  input  logic [31:0]       ld_dst,
  input  logic [31:0]       ld_data,
  input  logic              rec_ready,
  output logic              rec_valid,
  output logic [1:0]        rec_type,
  output logic [TIME_W-1:0] rec_time,
  output logic [31:0]       rec_pc,
  output logic [31:0]       rec_dst,
  output logic [31:0]       rec_data,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic accept;
  // A slot is free when empty or being drained at this very edge.
  assign accept = !rec_valid || rec_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec_valid <= 1'b0;
      rec_type  <= '0;
      rec_time  <= '0;
      rec_pc    <= '0;
      rec_dst   <= '0;
      rec_data  <= '0;
      drop_cnt  <= '0;
    end else if (load && accept) begin
      rec_valid <= 1'b1;
      rec_type  <= ld_type;
      rec_time  <= ld_time;
      rec_pc    <= ld_pc;
      rec_dst   <= ld_dst;
      rec_data  <= ld_data;
    end else if (load) begin
      if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end else if (rec_valid && rec_ready) begin
      rec_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_record_extractor.sv
// Parses the cpu trace char stream into time/pc/dst/data fields and publishes
// each record that the companion checker flags as legal.
module cpu_record_extractor
  import cpu_record_extractor_pkg::*;
#(
  parameter int unsigned TIME_W = 14,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:1]        char,
  input  logic [1:0]        format_type,
  input  logic              rec_ready,
  output logic              rec_valid,
  output logic [1:0]        rec_type,
  output logic [TIME_W-1:0] rec_time,
  output logic [31:0]       rec_pc,
  output logic [31:0]       rec_dst,
  output logic [31:0]       rec_data,
  output logic [CNT_W-1:0]  drop_cnt
);

  phase_e            phase_q, phase_d;
  logic [TIME_W-1:0] time_q, time_d, time_nxt;
  logic [31:0]       pc_q, pc_d, dst_q, dst_d, data_q, data_d;
  logic [13:0]       reg_nxt;
  logic [6:0]        c;
  logic [3:0]        nib;

  assign c   = char;
  assign nib = hex2nib(c);

  always_comb begin
    phase_d  = phase_q;
    time_d   = time_q;
    pc_d     = pc_q;
    dst_d    = dst_q;
    data_d   = data_q;
    // acc*10 + digit, truncated to the field width
    time_nxt = (time_q << 3) + (time_q << 1) + TIME_W'(c[3:0]);
    reg_nxt  = (dst_q[13:0] << 3) + (dst_q[13:0] << 1) + 14'(c[3:0]);
    if (c == ASC_CARET) begin
      phase_d = PhTime;
      time_d  = '0;
      pc_d    = '0;
      dst_d   = '0;
      data_d  = '0;
    end else begin
      unique case (phase_q)
        PhIdle: phase_d = PhIdle;
        PhTime: begin
          if (is_digit(c)) time_d = time_nxt;
          else phase_d = (c == ASC_AT) ? PhPc : PhIdle;
        end
        PhPc: begin
          if (is_hex(c)) pc_d = {pc_q[27:0], nib};
          else phase_d = (c == ASC_COLON) ? PhSep : PhIdle;
        end
        PhSep: begin
          if (c == ASC_DOLLAR) phase_d = PhReg;
          else if (c == ASC_STAR) phase_d = PhAddr;
          else if (c != ASC_SPACE) phase_d = PhIdle;
        end
        PhReg: begin
          if (is_digit(c)) dst_d = {18'd0, reg_nxt};
          else phase_d = (c == ASC_SPACE || c == ASC_LT) ? PhArrow : PhIdle;
        end
        PhAddr: begin
          if (is_hex(c)) dst_d = {dst_q[27:0], nib};
          else phase_d = (c == ASC_SPACE || c == ASC_LT) ? PhArrow : PhIdle;
        end
        PhArrow: begin
          if (is_hex(c)) begin
            data_d  = {data_q[27:0], nib};
            phase_d = PhData;
          end else if (c != ASC_SPACE && c != ASC_LT && c != ASC_EQ) begin
            phase_d = PhIdle;
          end
        end
        PhData: begin
          if (is_hex(c)) data_d = {data_q[27:0], nib};
          else phase_d = PhIdle;
        end
        default: phase_d = PhIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= PhIdle;
      time_q  <= '0;
      pc_q    <= '0;
      dst_q   <= '0;
      data_q  <= '0;
    end else begin
      phase_q <= phase_d;
      time_q  <= time_d;
      pc_q    <= pc_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
    end
  end

  // Payload comes from the current accumulators, so a '^' in the publish
  // cycle still hands over the completed record.
  record_out_reg #(
    .TIME_W(TIME_W),
    .CNT_W (CNT_W)
  ) u_out (
    .clk      (clk),
    .reset    (reset),
    .load     (format_type != FMT_NONE),
    .ld_type  (format_type),
    .ld_time  (time_q),
    .ld_pc    (pc_q),
    .ld_dst   (dst_q),
    .ld_data  (data_q),
    .rec_ready(rec_ready),
    .rec_valid(rec_valid),
    .rec_type (rec_type),
    .rec_time (rec_time),
    .rec_pc   (rec_pc),
    .rec_dst  (rec_dst),
    .rec_data (rec_data),
    .drop_cnt (drop_cnt)
  );

endmodule

// File: tb/tb_cpu_record_extractor.sv
// Scoreboard bench for cpu_record_extractor; format_type is driven as the
// checker would, one cycle after each '#'.
module tb_cpu_record_extractor;

  localparam int unsigned TIME_W = 14;
  localparam int unsigned CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:1]        char = 7'h20;
  logic [1:0]        format_type = 2'b00;
  logic              rec_ready = 1'b0;
  logic              rec_valid;
  logic [1:0]        rec_type;
  logic [TIME_W-1:0] rec_time;
  logic [31:0]       rec_pc, rec_dst, rec_data;
  logic [CNT_W-1:0]  drop_cnt;

  typedef struct {
    logic [1:0]        t;
    logic [TIME_W-1:0] tm;
    logic [31:0]       pc;
    logic [31:0]       dst;
    logic [31:0]       data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [1:0] fmt_pend = 2'b00;
  logic [1:0] line_fmt = 2'b00;
  logic       rdy_cur  = 1'b0;

  always #5 clk = ~clk;

  cpu_record_extractor #(
    .TIME_W(TIME_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .char       (char),
    .format_type(format_type),
    .rec_ready  (rec_ready),
    .rec_valid  (rec_valid),
    .rec_type   (rec_type),
    .rec_time   (rec_time),
    .rec_pc     (rec_pc),
    .rec_dst    (rec_dst),
    .rec_data   (rec_data),
    .drop_cnt   (drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_char(input byte b, input logic rdy);
    @(posedge clk);
    #1;
    char        = b[6:0];
    format_type = fmt_pend;
    rec_ready   = rdy;
    fmt_pend    = 2'b00;
    if (b == "#") fmt_pend = line_fmt;
  endtask

  task automatic send_line(input string s, input logic [1:0] fmt);
    byte b;
    line_fmt = fmt;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      drive_char(b, rdy_cur);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_char(" ", rdy_cur);
  endtask

  task automatic push(input logic [1:0] t, input logic [TIME_W-1:0] tm, input logic [31:0] pc,
                      input logic [31:0] dst, input logic [31:0] data);
    exp_t e;
    e.t = t; e.tm = tm; e.pc = pc; e.dst = dst; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      idle(1);
      n++;
    end
    @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  // Monitor: every transfer must match the oldest expected record.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && rec_valid && rec_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_transfer", {30'd0, rec_type}, 32'hffff_ffff);
      end else begin
        e = exp_q.pop_front();
        chk("rec_type", {30'd0, rec_type}, {30'd0, e.t});
        chk("rec_time", {18'd0, rec_time}, {18'd0, e.tm});
        chk("rec_pc", rec_pc, e.pc);
        chk("rec_dst", rec_dst, e.dst);
        chk("rec_data", rec_data, e.data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    chk("reset_valid", {31'd0, rec_valid}, 0);
    chk("reset_drop", {24'd0, drop_cnt}, 0);
    chk("reset_data", rec_data, 0);
    @(posedge clk); #1 reset = 1'b0;

    // 1: register record, ready high
    rdy_cur = 1'b1;
    send_line("^10@00003000: $1 <= 0000000a#", 2'b01);
    push(2'b01, 14'd10, 32'h3000, 32'd1, 32'ha);
    idle(4);
    drain("t1_drain");

    // 2: memory record at field limits
    send_line("^9999@bfc00000: *00001004 <= deadbeef#", 2'b10);
    push(2'b10, 14'd9999, 32'hbfc00000, 32'h1004, 32'hdeadbeef);
    idle(4);
    drain("t2_drain");

    // 4: malformed line is not published and leaves no stale digits
    send_line("^12@00003000: $3 <= 1x#", 2'b00);
    send_line("^34@00400010: $31 <= 12345678#", 2'b01);
    push(2'b01, 14'd34, 32'h00400010, 32'd31, 32'h12345678);
    idle(4);
    drain("t4_drain");

    // 5: '^' right after '#', ready pulsed in the publish cycle
    rdy_cur = 1'b0;
    send_line("^7@00000004: *000000ff <= cafef00d#", 2'b10);
    push(2'b10, 14'd7, 32'h4, 32'hff, 32'hcafef00d);
    drive_char("^", 1'b0);
    drive_char("8", 1'b1);
    send_line("@00000008: $0 <= 1#", 2'b01);
    push(2'b01, 14'd8, 32'h8, 32'd0, 32'h1);
    idle(3);
    @(negedge clk);
    chk("t5_queue_one", exp_q.size(), 1);
    chk("t5_valid_held", {31'd0, rec_valid}, 1);
    chk("t5_drop", {24'd0, drop_cnt}, 0);
    rdy_cur = 1'b1;
    drain("t5_drain");

    // 7: new record loads in the same cycle as a transfer
    rdy_cur = 1'b0;
    send_line("^100@abcdef01: $2 <= 00000002#", 2'b01);
    push(2'b01, 14'd100, 32'habcdef01, 32'd2, 32'h2);
    send_line("^101@abcdef02: *20 <= 30#", 2'b10);
    push(2'b10, 14'd101, 32'habcdef02, 32'h20, 32'h30);
    drive_char(" ", 1'b1);
    idle(3);
    @(negedge clk);
    chk("t7_valid", {31'd0, rec_valid}, 1);
    chk("t7_data", rec_data, 32'h30);
    chk("t7_drop", {24'd0, drop_cnt}, 0);
    rdy_cur = 1'b1;
    drain("t7_drain");

    // 3: back-pressure, drop counting and saturation
    rdy_cur = 1'b0;
    send_line("^5@10: $4 <= 6#", 2'b01);
    push(2'b01, 14'd5, 32'h10, 32'd4, 32'h6);
    send_line("^6@20: $5 <= 7#", 2'b01);
    idle(2);
    @(negedge clk);
    chk("t3_drop1", {24'd0, drop_cnt}, 1);
    chk("t3_held_time", {18'd0, rec_time}, 5);
    chk("t3_held_data", rec_data, 32'h6);
    for (int i = 0; i < 261; i++) send_line("^6@20: $5 <= 7#", 2'b01);
    idle(2);
    @(negedge clk);
    chk("t3_drop_sat", {24'd0, drop_cnt}, 32'hff);
    rdy_cur = 1'b1;
    drain("t3_drain");

    // 6: asynchronous reset mid-DATA
    rdy_cur = 1'b0;
    send_line("^55@1234: $9 <= ab", 2'b00);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", {31'd0, rec_valid}, 0);
    chk("t6_rst_drop", {24'd0, drop_cnt}, 0);
    chk("t6_rst_time", {18'd0, rec_time}, 0);
    chk("t6_rst_pc", rec_pc, 0);
    fmt_pend = 2'b00;
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b0;
    rdy_cur = 1'b1;
    send_line("^66@5678: *abc <= def#", 2'b10);
    push(2'b10, 14'd66, 32'h5678, 32'habc, 32'hdef);
    idle(4);
    drain("t6_drain");
    @(negedge clk);
    chk("t6_drop", {24'd0, drop_cnt}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
